// File: rtl/mux2_arbiter.sv
// Round-robin controller for a shared 2:1 mux: registered grants and select,
// a bounded hold time with preemption, and a fixed dead gap between owners.
module mux2_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int GAP      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req1,
  input  logic       req2,
  output logic       gnt1,
  output logic       gnt2,
  output logic       sel,
  output logic       busy,
  output logic       preempt,
  output logic [1:0] dbg_state
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("mux2_arbiter: MAX_HOLD must be in 2..255");
  end
  if (GAP < 1 || GAP > 15) begin : g_bad_gap
    $error("mux2_arbiter: GAP must be in 1..15");
  end

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
  localparam logic [3:0] GAP_LIMIT  = 4'(GAP);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT1 = 2'd1,
    GRANT2 = 2'd2,
    GAP_ST = 2'd3
  } state_t;

  state_t     state, state_d;
  logic [7:0] hold_cnt, hold_cnt_d;
  logic [3:0] gap_cnt, gap_cnt_d;
  logic       last_two, last_two_d;   // 1 = requester 2 was served last
  logic       sel_d, preempt_d;
  logic       any_req, pick_two;

  // Tie goes to whichever requester was not served last.
  assign any_req  = req1 | req2;
  assign pick_two = req2 & (~req1 | ~last_two);

  always_comb begin
    state_d    = state;
    hold_cnt_d = hold_cnt;
    gap_cnt_d  = gap_cnt;
    last_two_d = last_two;
    sel_d      = sel;
    preempt_d  = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_d    = pick_two ? GRANT2 : GRANT1;
          sel_d      = pick_two;
          last_two_d = pick_two;
          hold_cnt_d = 8'd1;
        end
      end
      GRANT1: begin
        if (!req1) begin
          state_d   = GAP_ST;
          gap_cnt_d = 4'd1;
        end else if (hold_cnt == HOLD_LIMIT && req2) begin
          state_d   = GAP_ST;
          gap_cnt_d = 4'd1;
          preempt_d = 1'b1;
        end else if (hold_cnt != HOLD_LIMIT) begin
          hold_cnt_d = hold_cnt + 8'd1;
        end
      end
      GRANT2: begin
        if (!req2) begin
          state_d   = GAP_ST;
          gap_cnt_d = 4'd1;
        end else if (hold_cnt == HOLD_LIMIT && req1) begin
          state_d   = GAP_ST;
          gap_cnt_d = 4'd1;
          preempt_d = 1'b1;
        end else if (hold_cnt != HOLD_LIMIT) begin
          hold_cnt_d = hold_cnt + 8'd1;
        end
      end
      GAP_ST: begin
        // Arbitrate in the last gap cycle so the next grant lands exactly GAP cycles later.
        if (gap_cnt == GAP_LIMIT) begin
          if (any_req) begin
            state_d    = pick_two ? GRANT2 : GRANT1;
            sel_d      = pick_two;
            last_two_d = pick_two;
            hold_cnt_d = 8'd1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= 8'd0;
      gap_cnt  <= 4'd0;
      last_two <= 1'b1;
      sel      <= 1'b0;
      gnt1     <= 1'b0;
      gnt2     <= 1'b0;
      busy     <= 1'b0;
      preempt  <= 1'b0;
    end else begin
      state    <= state_d;
      hold_cnt <= hold_cnt_d;
      gap_cnt  <= gap_cnt_d;
      last_two <= last_two_d;
      sel      <= sel_d;
      gnt1     <= (state_d == GRANT1);
      gnt2     <= (state_d == GRANT2);
      busy     <= (state_d != IDLE);
      preempt  <= preempt_d;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed bench for mux2_arbiter (MAX_HOLD=4, GAP=1); each step checks
// {gnt1,gnt2,sel,busy,preempt} one time unit after the rising edge.
module tb_mux2_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req1 = 1'b0;
  logic       req2 = 1'b0;
  logic       gnt1, gnt2, sel, busy, preempt;
  logic [1:0] dbg_state;

  int total = 0;
  int bad   = 0;

  mux2_arbiter #(.MAX_HOLD(4), .GAP(1)) dut (
    .clk(clk), .rst(rst), .req1(req1), .req2(req2),
    .gnt1(gnt1), .gnt2(gnt2), .sel(sel), .busy(busy), .preempt(preempt),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Drive inputs on the falling edge, sample outputs 1 after the rising edge.
  task automatic cyc(input logic r, input logic r1, input logic r2,
                     input string tag, input logic [4:0] exp_v);
    logic [4:0] obs;
    @(negedge clk);
    rst  = r;
    req1 = r1;
    req2 = r2;
    @(posedge clk);
    #1;
    obs = {gnt1, gnt2, sel, busy, preempt};
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: got g1g2 sel busy pre=%b want %b", tag, obs, exp_v);
    end
  endtask

  logic [4:0] alt_pat [10];

  initial begin
    alt_pat = '{5'b10010, 5'b10010, 5'b10010, 5'b00011, 5'b01110,
                5'b01110, 5'b01110, 5'b01110, 5'b00111, 5'b10010};

    // Reset held with both requests, then first tie to requester 1.
    cyc(1, 1, 1, "reset0", 5'b00000);
    cyc(1, 1, 1, "reset1", 5'b00000);
    cyc(0, 1, 1, "first_tie", 5'b10010);

    // Preemption then alternation under continuous load.
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < 10; i++) begin
        cyc(0, 1, 1, $sformatf("alt_r%0d_c%0d", rep, i), alt_pat[i]);
      end
    end
    cyc(0, 0, 0, "alt_release", 5'b00010);
    cyc(0, 0, 0, "alt_idle", 5'b00000);

    // Requester 1 alone for 20 cycles: no timeout.
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 0, $sformatf("alone_c%0d", i), 5'b10010);
    end
    cyc(0, 0, 0, "alone_gap", 5'b00010);
    cyc(0, 0, 0, "alone_idle", 5'b00000);

    // Owner drops on its 4th cycle while req2 waits: release, not preempt.
    cyc(0, 1, 0, "drop_c1", 5'b10010);
    cyc(0, 1, 1, "drop_c2", 5'b10010);
    cyc(0, 1, 1, "drop_c3", 5'b10010);
    cyc(0, 1, 1, "drop_c4", 5'b10010);
    cyc(0, 0, 1, "drop_release", 5'b00010);
    cyc(0, 0, 1, "drop_g2", 5'b01110);
    cyc(0, 0, 1, "drop_g2_b", 5'b01110);

    // Reset in the middle of GRANT2, then a tie goes to requester 1.
    cyc(1, 1, 1, "mid_reset", 5'b00000);
    cyc(0, 1, 1, "post_reset_tie", 5'b10010);

    // Waiting requester drops during the gap: nobody is granted.
    cyc(0, 0, 1, "gap_release", 5'b00010);
    cyc(0, 0, 0, "gap_dropped", 5'b00000);

    // Old owner (1) re-requests against 2: tie goes to 2; sel then holds at 1.
    cyc(0, 1, 1, "rr_tie_to2", 5'b01110);
    cyc(0, 1, 0, "rr_release", 5'b00110);
    cyc(0, 0, 0, "rr_idle_sel", 5'b00100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
